// File: rtl/bram_arbiter.sv
// Purpose : two-requester arbiter serialising accesses to a single-port block RAM.
// Latency : grant/strobe one cycle after the IDLE sample; read data returns RD_LAT+2 cycles after the sample.
// Backpressure: requester holds req with stable fields until its gnt pulse; no sampling while busy.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata   requester A command (held until a_gnt)
//   a_gnt, a_rvalid, a_rdata    A grant pulse, read-data valid pulse, read data (held)
//   b_*                         same set for requester B
//   ram_write, ram_read         one-cycle RAM strobes
//   ram_addr, ram_din           RAM address / write data, change only on a grant
//   ram_dout                    RAM read data, valid RD_LAT cycles after ram_read
//   busy                        high whenever the arbiter is not in IDLE
// Optional build macro: BRAM_ARB_RR_EN selects round-robin tie-break instead of
// fixed A-over-B priority.
module bram_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              ram_write,
  output logic              ram_read,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RDWAIT = 2'd2} state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;   // 0 = A, 1 = B
  logic                we_q, we_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                ram_write_q, ram_write_d;
  logic                ram_read_q, ram_read_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_din_q, ram_din_d;
  logic                a_gnt_q, a_gnt_d;
  logic                b_gnt_q, b_gnt_d;
  logic                a_rvalid_q, a_rvalid_d;
  logic                b_rvalid_q, b_rvalid_d;
  logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;
  logic                pick_b;
  logic                win_we;

`ifdef BRAM_ARB_RR_EN
  // Pointer holds the last granted requester; the other one wins a tie.
  logic last_b_q, last_b_d;
  assign pick_b = b_req & (~a_req | ~last_b_q);
`else
  assign pick_b = b_req & ~a_req;
`endif

  assign win_we = pick_b ? b_we : a_we;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    ram_write_d = 1'b0;
    ram_read_d  = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    a_gnt_d     = 1'b0;
    b_gnt_d     = 1'b0;
    a_rvalid_d  = 1'b0;
    b_rvalid_d  = 1'b0;
    a_rdata_d   = a_rdata_q;
    b_rdata_d   = b_rdata_q;
`ifdef BRAM_ARB_RR_EN
    last_b_d    = last_b_q;
`endif
    case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          ram_addr_d  = pick_b ? b_addr  : a_addr;
          ram_din_d   = pick_b ? b_wdata : a_wdata;
          ram_write_d = win_we;
          ram_read_d  = ~win_we;
          a_gnt_d     = ~pick_b;
          b_gnt_d     = pick_b;
          owner_d     = pick_b;
          we_d        = win_we;
`ifdef BRAM_ARB_RR_EN
          last_b_d    = pick_b;
`endif
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d = IDLE;
        end else begin
          cnt_d   = 2'(RD_LAT);
          state_d = RDWAIT;
        end
      end
      RDWAIT: begin
        cnt_d = cnt_q - 2'd1;
        // Last wait cycle: ram_dout is valid now, so capture it; the rvalid
        // pulse and the new rdata appear together in the next (IDLE) cycle.
        if (cnt_q == 2'd1) begin
          if (owner_q) begin
            b_rdata_d  = ram_dout;
            b_rvalid_d = 1'b1;
          end else begin
            a_rdata_d  = ram_dout;
            a_rvalid_d = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      cnt_q       <= 2'd0;
      ram_write_q <= 1'b0;
      ram_read_q  <= 1'b0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      a_gnt_q     <= 1'b0;
      b_gnt_q     <= 1'b0;
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
`ifdef BRAM_ARB_RR_EN
      last_b_q    <= 1'b1;  // B counted as last winner so A takes the first tie
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      ram_write_q <= ram_write_d;
      ram_read_q  <= ram_read_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      a_gnt_q     <= a_gnt_d;
      b_gnt_q     <= b_gnt_d;
      a_rvalid_q  <= a_rvalid_d;
      b_rvalid_q  <= b_rvalid_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
`ifdef BRAM_ARB_RR_EN
      last_b_q    <= last_b_d;
`endif
    end
  end

  assign a_gnt     = a_gnt_q;
  assign b_gnt     = b_gnt_q;
  assign a_rvalid  = a_rvalid_q;
  assign b_rvalid  = b_rvalid_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;
  assign ram_write = ram_write_q;
  assign ram_read  = ram_read_q;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_bram_arbiter.sv
// Self-checking bench for bram_arbiter: main instance with RD_LAT=1, second
// instance (x_*) with RD_LAT=2. Each instance drives a behavioural RAM.
module tb_bram_arbiter;

  localparam int NCYC = 400;
  localparam int NE   = NCYC + 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       a_req = 0, a_we = 0, a_gnt, a_rvalid;
  logic [3:0] a_addr = 0;
  logic [7:0] a_wdata = 0, a_rdata;
  logic       b_req = 0, b_we = 0, b_gnt, b_rvalid;
  logic [3:0] b_addr = 0;
  logic [7:0] b_wdata = 0, b_rdata;
  logic       ram_write, ram_read, busy;
  logic [3:0] ram_addr;
  logic [7:0] ram_din, ram_dout;

  logic       x_a_req = 0, x_a_we = 0, x_a_gnt, x_a_rvalid;
  logic [3:0] x_a_addr = 0;
  logic [7:0] x_a_wdata = 0, x_a_rdata;
  logic       x_b_req = 0, x_b_we = 0, x_b_gnt, x_b_rvalid;
  logic [3:0] x_b_addr = 0;
  logic [7:0] x_b_wdata = 0, x_b_rdata;
  logic       x_ram_write, x_ram_read, x_busy;
  logic [3:0] x_ram_addr;
  logic [7:0] x_ram_din, x_ram_dout;

  int checks = 0;
  int errors = 0;

  bram_arbiter #(.ADDR_W(4), .DATA_W(8), .RD_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_write(ram_write), .ram_read(ram_read), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout), .busy(busy)
  );

  bram_arbiter #(.ADDR_W(4), .DATA_W(8), .RD_LAT(2)) dut_lat2 (
    .clk(clk), .reset(reset),
    .a_req(x_a_req), .a_we(x_a_we), .a_addr(x_a_addr), .a_wdata(x_a_wdata),
    .a_gnt(x_a_gnt), .a_rvalid(x_a_rvalid), .a_rdata(x_a_rdata),
    .b_req(x_b_req), .b_we(x_b_we), .b_addr(x_b_addr), .b_wdata(x_b_wdata),
    .b_gnt(x_b_gnt), .b_rvalid(x_b_rvalid), .b_rdata(x_b_rdata),
    .ram_write(x_ram_write), .ram_read(x_ram_read), .ram_addr(x_ram_addr),
    .ram_din(x_ram_din), .ram_dout(x_ram_dout), .busy(x_busy)
  );

  // Behavioural RAMs: dout is valid RD_LAT cycles after the read strobe,
  // zero otherwise so a mistimed capture shows up as wrong data.
  logic [7:0] ram_mem [16];
  logic [7:0] ram_p0;
  always @(posedge clk) begin
    if (ram_write) ram_mem[ram_addr] <= ram_din;
    ram_p0 <= ram_read ? ram_mem[ram_addr] : 8'h00;
  end
  assign ram_dout = ram_p0;

  logic [7:0] x_mem [16];
  logic [7:0] x_p0, x_p1;
  always @(posedge clk) begin
    if (x_ram_write) x_mem[x_ram_addr] <= x_ram_din;
    x_p0 <= x_ram_read ? x_mem[x_ram_addr] : 8'h00;
    x_p1 <= x_p0;
  end
  assign x_ram_dout = x_p1;

  // {a_gnt, b_gnt, ram_write, ram_read, a_rvalid, b_rvalid, busy}
  function automatic logic [6:0] flags();
    return {a_gnt, b_gnt, ram_write, ram_read, a_rvalid, b_rvalid, busy};
  endfunction
  function automatic logic [6:0] x_flags();
    return {x_a_gnt, x_b_gnt, x_ram_write, x_ram_read, x_a_rvalid, x_b_rvalid, x_busy};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1; a_req = 1; a_we = 1; a_addr = 4'd1; a_wdata = 8'h11;
    b_req = 1; b_we = 1; b_addr = 4'd2; b_wdata = 8'h22;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({flags(), ram_addr, ram_din, a_rdata, b_rdata} !== 35'd0) begin
        errors++;
        $display("FAIL reset_outputs cyc %0d got flags=%b addr=%h din=%h ard=%h brd=%h required all 0",
                 i, flags(), ram_addr, ram_din, a_rdata, b_rdata);
      end
      checks++;
      if ({x_flags(), x_ram_addr, x_ram_din, x_a_rdata, x_b_rdata} !== 35'd0) begin
        errors++;
        $display("FAIL reset_outputs_lat2 cyc %0d got flags=%b required 0", i, x_flags());
      end
    end
    reset = 0;  // this cycle is the IDLE sample cycle
    step();     // grant cycle
    checks++;
    if (flags() !== 7'b1010001 || ram_addr !== 4'd1 || ram_din !== 8'h11) begin
      errors++;
      $display("FAIL first_grant got flags=%b addr=%h din=%h required 1010001 1 11", flags(), ram_addr, ram_din);
    end
    a_req = 0; b_req = 0;
    step();
    checks++;
    if (flags() !== 7'd0) begin
      errors++;
      $display("FAIL post_first_grant got flags=%b required 0000000", flags());
    end
  endtask

  task automatic test_write_a();
    a_req = 1; a_we = 1; a_addr = 4'd3; a_wdata = 8'hA5;
    step();
    checks++;
    if (flags() !== 7'b1010001 || ram_addr !== 4'd3 || ram_din !== 8'hA5) begin
      errors++;
      $display("FAIL write_a_grant got flags=%b addr=%h din=%h required 1010001 3 a5", flags(), ram_addr, ram_din);
    end
    a_req = 0;
    step();
    checks++;
    if (flags() !== 7'd0 || ram_addr !== 4'd3 || ram_din !== 8'hA5) begin
      errors++;
      $display("FAIL write_a_after got flags=%b addr=%h din=%h required 0000000 3 a5", flags(), ram_addr, ram_din);
    end
  endtask

  task automatic test_read_b();
    b_req = 1; b_we = 0; b_addr = 4'd3; b_wdata = 8'h5A;
    step();
    checks++;
    if (flags() !== 7'b0101001 || ram_addr !== 4'd3) begin
      errors++;
      $display("FAIL read_b_grant got flags=%b addr=%h required 0101001 3", flags(), ram_addr);
    end
    b_req = 0;
    step();
    checks++;
    if (flags() !== 7'b0000001) begin
      errors++;
      $display("FAIL read_b_wait got flags=%b required 0000001", flags());
    end
    step();
    checks++;
    if (flags() !== 7'b0000010 || b_rdata !== 8'hA5 || a_rdata !== 8'h00) begin
      errors++;
      $display("FAIL read_b_rvalid got flags=%b brd=%h ard=%h required 0000010 a5 00", flags(), b_rdata, a_rdata);
    end
    step();
    checks++;
    if (flags() !== 7'd0 || b_rdata !== 8'hA5) begin
      errors++;
      $display("FAIL read_b_hold got flags=%b brd=%h required 0000000 a5", flags(), b_rdata);
    end
  endtask

  task automatic test_conflict();
    logic [3:0] exp_b;
`ifdef BRAM_ARB_RR_EN
    exp_b = 4'b1010;
`else
    exp_b = 4'b0000;
`endif
    a_req = 1; a_we = 1; a_addr = 4'd4; a_wdata = 8'h44;
    b_req = 1; b_we = 1; b_addr = 4'd5; b_wdata = 8'h55;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (i % 2 == 0) begin
        if (flags() !== (exp_b[i/2] ? 7'b0110001 : 7'b1010001)) begin
          errors++;
          $display("FAIL conflict_grant %0d got flags=%b required winner %s", i/2, flags(), exp_b[i/2] ? "B" : "A");
        end
        if (i == 6) begin a_req = 0; b_req = 0; end
      end else if (flags() !== 7'd0) begin
        errors++;
        $display("FAIL conflict_gap %0d got flags=%b required 0000000", i, flags());
      end
    end
  endtask

  task automatic test_reset_mid();
    b_req = 1; b_we = 0; b_addr = 4'd3;
    step();  // grant
    b_req = 0;
    step();  // RDWAIT
    reset = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (flags() !== 7'd0 || b_rdata !== 8'h00 || ram_addr !== 4'd0) begin
        errors++;
        $display("FAIL reset_mid %0d got flags=%b brd=%h addr=%h required 0", i, flags(), b_rdata, ram_addr);
      end
    end
    reset = 0;
    b_req = 1; b_we = 1; b_addr = 4'd9; b_wdata = 8'h99;
    step();
    checks++;
    if (flags() !== 7'b0110001 || ram_addr !== 4'd9 || ram_din !== 8'h99) begin
      errors++;
      $display("FAIL reset_mid_next got flags=%b addr=%h din=%h required 0110001 9 99", flags(), ram_addr, ram_din);
    end
    b_req = 0;
    step();
    checks++;
    if (flags() !== 7'd0) begin
      errors++;
      $display("FAIL reset_mid_after got flags=%b required 0000000", flags());
    end
  endtask

  task automatic test_lat2();
    logic [6:0] exp_f [6];
    exp_f[0] = 7'b0000000;  // M: sample cycle
    exp_f[1] = 7'b1001001;  // M+1: gnt, ram_read
    exp_f[2] = 7'b0000001;  // M+2
    exp_f[3] = 7'b0000001;  // M+3
    exp_f[4] = 7'b0000100;  // M+4: a_rvalid
    exp_f[5] = 7'b0000000;
    x_a_req = 1; x_a_we = 1; x_a_addr = 4'd7; x_a_wdata = 8'h3C;
    step();
    checks++;
    if (x_flags() !== 7'b1010001) begin
      errors++;
      $display("FAIL lat2_write got flags=%b required 1010001", x_flags());
    end
    x_a_we = 0;  // next request presented in the grant cycle
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (x_flags() !== exp_f[i]) begin
        errors++;
        $display("FAIL lat2_seq M+%0d got flags=%b required %b", i, x_flags(), exp_f[i]);
      end
      if (i == 1) x_a_req = 0;
      if (i >= 4) begin
        checks++;
        if (x_a_rdata !== 8'h3C) begin
          errors++;
          $display("FAIL lat2_rdata M+%0d got %h required 3c", i, x_a_rdata);
        end
      end
    end
  endtask

  // Transaction-level reference: each sample fixes the cycles of grant,
  // strobe, busy and rvalid by arithmetic from the sample cycle.
  task automatic test_random();
    bit         e_ag [NE], e_bg [NE], e_wr [NE], e_rd [NE], e_av [NE], e_bv [NE], e_busy [NE];
    logic [7:0] e_addr [NE], e_din [NE], e_rdat [NE];
    logic [7:0] mdl_mem [16];
    logic [7:0] ea, ed, ear, ebr;
    int         free_at, t, r;
    bit         last_b, wb, we;
    logic [3:0] ad;
    logic [7:0] wd;
    // preload RAM with known contents through port A
    for (int i = 0; i < 16; i++) begin
      mdl_mem[i] = 8'($urandom);
      a_req = 1; a_we = 1; a_addr = 4'(i); a_wdata = mdl_mem[i];
      step();
      a_req = 0;
      step();
    end
    reset = 1;
    step();
    step();
    reset = 0;
    for (int c = 0; c < NE; c++) begin
      e_ag[c] = 0; e_bg[c] = 0; e_wr[c] = 0; e_rd[c] = 0;
      e_av[c] = 0; e_bv[c] = 0; e_busy[c] = 0;
      e_addr[c] = 0; e_din[c] = 0; e_rdat[c] = 0;
    end
    ea = 0; ed = 0; ear = 0; ebr = 0; free_at = 0; last_b = 1;
    for (int c = 0; c < NCYC + 20; c++) begin
      step();
      if (e_ag[c] || e_bg[c]) begin ea = e_addr[c]; ed = e_din[c]; end
      if (e_av[c]) ear = e_rdat[c];
      if (e_bv[c]) ebr = e_rdat[c];
      checks++;
      if (flags() !== {e_ag[c], e_bg[c], e_wr[c], e_rd[c], e_av[c], e_bv[c], e_busy[c]}) begin
        errors++;
        $display("FAIL rand_flags cyc %0d got %b required %b", c, flags(),
                 {e_ag[c], e_bg[c], e_wr[c], e_rd[c], e_av[c], e_bv[c], e_busy[c]});
      end
      checks++;
      if ({ram_addr, ram_din} !== {ea, ed}) begin
        errors++;
        $display("FAIL rand_addr_din cyc %0d got %h/%h required %h/%h", c, ram_addr, ram_din, ea, ed);
      end
      checks++;
      if ({a_rdata, b_rdata} !== {ear, ebr}) begin
        errors++;
        $display("FAIL rand_rdata cyc %0d got %h/%h required %h/%h", c, a_rdata, b_rdata, ear, ebr);
      end
      // requesters: hold until granted, then idle or issue a new request
      if (!a_req || e_ag[c]) begin
        a_req = (c < NCYC) && ($urandom_range(0, 2) != 0);
        a_we = 1'($urandom_range(0, 1)); a_addr = 4'($urandom_range(0, 15)); a_wdata = 8'($urandom);
      end
      if (!b_req || e_bg[c]) begin
        b_req = (c < NCYC) && ($urandom_range(0, 2) != 0);
        b_we = 1'($urandom_range(0, 1)); b_addr = 4'($urandom_range(0, 15)); b_wdata = 8'($urandom);
      end
      if (c >= free_at && (a_req || b_req)) begin
        if (a_req && b_req) begin
`ifdef BRAM_ARB_RR_EN
          wb = !last_b;
`else
          wb = 0;
`endif
        end else begin
          wb = b_req;
        end
        last_b = wb;
        we = wb ? b_we : a_we;
        ad = wb ? b_addr : a_addr;
        wd = wb ? b_wdata : a_wdata;
        t = c + 1;
        e_ag[t] = !wb; e_bg[t] = wb; e_wr[t] = we; e_rd[t] = !we;
        e_addr[t] = ad; e_din[t] = wd;
        if (we) begin
          mdl_mem[ad] = wd;
          e_busy[t] = 1;
          free_at = c + 2;
        end else begin
          r = c + 3;  // sample + 2 + RD_LAT(1)
          for (int k = t; k < r; k++) e_busy[k] = 1;
          if (wb) e_bv[r] = 1; else e_av[r] = 1;
          e_rdat[r] = mdl_mem[ad];
          free_at = r;
        end
      end
    end
    a_req = 0; b_req = 0;
  endtask

  initial begin
    test_reset();
    test_write_a();
    test_read_b();
    test_conflict();
    test_reset_mid();
    test_lat2();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
